pc_sequencer: RTL

//  Parametrised program-counter unit; successor to the plain PC register.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_next_mux.sv | 89 ++++++++
 rtl/pc_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: the control state
// encoding and the default boot, exception and increment constants.
// Build option: define PC_ALIGN_CHECK_EN to turn misaligned redirects into
// alignment faults instead of silently clearing the low address bits.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0180;
  localparam int          DEF_PC_INC    = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-state selection for the sequencer: decides where the
// PC goes next, what gets saved as the exception return address and which
// control state follows, in strict priority order.
// Build option: PC_ALIGN_CHECK_EN enables misaligned-redirect faulting.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int          N       = 32,
  parameter logic [N-1:0] EXC_VEC = DEF_EXC_VEC[N-1:0],
  parameter int          PC_INC  = DEF_PC_INC
) (
  input  pc_state_t      i_state,
  input  logic [N-1:0]   i_pc,
  input  logic [N-1:0]   i_epc,
  input  logic           i_stall,
  input  logic           i_redirectVld,
  input  logic [N-1:0]   i_redirectPc,
  input  logic           i_excReq,
  input  logic           i_eret,
  output logic [N-1:0]   o_nextPc,
  output logic [N-1:0]   o_nextEpc,
  output pc_state_t      o_nextState,
  output logic           o_nextAlignFault
);

  localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

  logic [N-1:0] w_redirAligned;
  logic [N-1:0] w_pcSeq;
`ifdef PC_ALIGN_CHECK_EN
  logic         w_misaligned;
  assign w_misaligned = |i_redirectPc[1:0];
`endif

  assign w_redirAligned = i_redirectPc & ALIGN_MASK;
  assign w_pcSeq        = i_pc + N'(PC_INC);

  // Priority select: exception entry, then return, then redirect, then step, else hold
  always_comb begin
    o_nextPc         = i_pc;
    o_nextEpc        = i_epc;
    o_nextState      = i_state;
    o_nextAlignFault = 1'b0;
    case (i_state)
      BOOT: begin
        o_nextState = RUN;
      end
      RUN: begin
        if (i_excReq) begin
          o_nextEpc   = i_pc;
          o_nextPc    = EXC_VEC;
          o_nextState = HANDLER;
        end else if (i_redirectVld && !i_stall) begin
`ifdef PC_ALIGN_CHECK_EN
          if (w_misaligned) begin
            o_nextEpc        = i_redirectPc;
            o_nextPc         = EXC_VEC;
            o_nextState      = HANDLER;
            o_nextAlignFault = 1'b1;
          end else begin
            o_nextPc = w_redirAligned;
          end
`else
          o_nextPc = w_redirAligned;
`endif
        end else if (!i_stall) begin
          o_nextPc = w_pcSeq;
        end
      end
      HANDLER: begin
        if (i_eret) begin
          o_nextPc    = i_epc;
          o_nextState = RUN;
        end else if (i_redirectVld && !i_stall) begin
          o_nextPc = w_redirAligned;
`ifdef PC_ALIGN_CHECK_EN
          o_nextAlignFault = w_misaligned;
`endif
        end else if (!i_stall) begin
          o_nextPc = w_pcSeq;
        end
      end
      default: begin
        o_nextState = BOOT;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC driving the instruction ROM
// and layers stall, branch/jump redirect, exception entry and ERET return on
// top of the plain sequential increment. Boots from the ROM base address.
// Build option: PC_ALIGN_CHECK_EN enables the align_fault pulse.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int           N         = 32,
  parameter logic [N-1:0] RESET_VEC = DEF_RESET_VEC[N-1:0],
  parameter logic [N-1:0] EXC_VEC   = DEF_EXC_VEC[N-1:0],
  parameter int           PC_INC    = DEF_PC_INC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_vld,
  input  logic [N-1:0] redirect_pc,
  input  logic         exc_req,
  input  logic         eret,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus_inc,
  output logic         pc_valid,
  output logic [N-1:0] epc,
  output logic         in_handler,
  output logic         align_fault
);

  pc_state_t    r_state;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_epc;
  logic         r_pcValid;
  logic         r_alignFault;

  pc_state_t    w_nextState;
  logic [N-1:0] w_nextPc;
  logic [N-1:0] w_nextEpc;
  logic         w_nextAlignFault;

  pc_next_mux #(
    .N       (N),
    .EXC_VEC (EXC_VEC),
    .PC_INC  (PC_INC)
  ) u_nextMux (
    .i_state          (r_state),
    .i_pc             (r_pc),
    .i_epc            (r_epc),
    .i_stall          (stall),
    .i_redirectVld    (redirect_vld),
    .i_redirectPc     (redirect_pc),
    .i_excReq         (exc_req),
    .i_eret           (eret),
    .o_nextPc         (w_nextPc),
    .o_nextEpc        (w_nextEpc),
    .o_nextState      (w_nextState),
    .o_nextAlignFault (w_nextAlignFault)
  );

  // State registers; reset wins over everything and discards any saved return PC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VEC;
      r_epc        <= '0;
      r_pcValid    <= 1'b0;
      r_alignFault <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_epc        <= w_nextEpc;
      r_pcValid    <= 1'b1;
      r_alignFault <= w_nextAlignFault;
    end
  end

  assign pc          = r_pc;
  assign pc_plus_inc = r_pc + N'(PC_INC);
  assign pc_valid    = r_pcValid;
  assign epc         = r_epc;
  assign in_handler  = (r_state == HANDLER);
  assign align_fault = r_alignFault;

endmodule
